// File: rtl/sdram_req_arb_pkg.sv
// Shared encodings for the SDRAM request arbiter: command codes handed to
// the work-state engine, arbiter states and the read/write history bit used
// for round-robin between the two data clients.
package sdram_req_arb_pkg;

    // Command codes seen by the SDRAM work-state FSM (0 means no command).
    typedef enum logic [1:0] {
        CMD_NONE = 2'd0,
        CMD_REF  = 2'd1,
        CMD_WR   = 2'd2,
        CMD_RD   = 2'd3
    } cmd_t;

    // Arbiter states.
    typedef enum logic [1:0] {
        A_INIT  = 2'd0,
        A_IDLE  = 2'd1,
        A_ISSUE = 2'd2,
        A_BUSY  = 2'd3
    } arb_state_t;

    // Which data client was served last; refresh never changes it.
    typedef enum logic {
        RW_WR = 1'b0,
        RW_RD = 1'b1
    } rw_t;

    // Width of the busy watchdog counter.
    localparam int WD_W = 9;

endpackage : sdram_req_arb_pkg

// File: rtl/sdram_req_arb.sv
// SDRAM request arbiter: shares the single SDRAM command engine between the
// refresh request, one write client and one read client. Refresh has strict
// priority, write and read alternate, and no new data command starts inside
// the refresh window. A watchdog flags an engine that never reports done.
module sdram_req_arb
    import sdram_req_arb_pkg::*;
#(
    parameter int ADDR_W  = 22,
    parameter int TIMEOUT = 511
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              init_done,
    input  logic              ref_domain,
    input  logic              ref_req,
    output logic              ref_ack,
    input  logic              wr_req,
    input  logic [ADDR_W-1:0] wr_addr,
    output logic              wr_ack,
    output logic              wr_done,
    input  logic              rd_req,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic              rd_ack,
    output logic              rd_done,
    output logic              cmd_valid,
    output logic [1:0]        cmd_type,
    output logic [ADDR_W-1:0] cmd_addr,
    input  logic              cmd_ready,
    input  logic              cmd_done,
    output logic              arb_busy,
    output logic              arb_err
);

    // Watchdog limit expressed in the counter's own width.
    localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(TIMEOUT);

    arb_state_t        state;
    cmd_t              owner;
    rw_t               last_rw;
    logic [WD_W-1:0]   wd_cnt;

    cmd_t              grant;
    logic [ADDR_W-1:0] grant_addr;

    // Grant decision from the current request levels (used only in A_IDLE).
    always_comb begin
        // NOTE: every output of a combinational block gets a default first, so
        // no path through the if/case can leave it unassigned and infer a latch.
        grant      = CMD_NONE;
        grant_addr = '0;
        if (ref_req) begin
            grant = CMD_REF;
        end else if (!ref_domain) begin
            if (wr_req && rd_req) begin
                grant = (last_rw == RW_RD) ? CMD_WR : CMD_RD;
            end else if (wr_req) begin
                grant = CMD_WR;
            end else if (rd_req) begin
                grant = CMD_RD;
            end
        end
        case (grant)
            CMD_WR:  grant_addr = wr_addr;
            CMD_RD:  grant_addr = rd_addr;
            default: grant_addr = '0;
        endcase
    end

    // Arbiter FSM with registered command, handshake pulses and watchdog.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: all state here is updated with non-blocking assignments so
        // every register samples the pre-edge values, regardless of order.
        if (!rst_n) begin
            state     <= A_INIT;
            owner     <= CMD_NONE;
            last_rw   <= RW_RD;
            wd_cnt    <= '0;
            ref_ack   <= 1'b0;
            wr_ack    <= 1'b0;
            wr_done   <= 1'b0;
            rd_ack    <= 1'b0;
            rd_done   <= 1'b0;
            cmd_valid <= 1'b0;
            cmd_type  <= CMD_NONE;
            cmd_addr  <= '0;
            arb_busy  <= 1'b0;
            arb_err   <= 1'b0;
        end else begin
            // Acks and dones are single-cycle pulses unless set below.
            ref_ack <= 1'b0;
            wr_ack  <= 1'b0;
            rd_ack  <= 1'b0;
            wr_done <= 1'b0;
            rd_done <= 1'b0;

            case (state)
                A_INIT: begin
                    // Requests are ignored until the SDRAM init sequence is over.
                    if (init_done) begin
                        state <= A_IDLE;
                    end
                end

                A_IDLE: begin
                    if (grant != CMD_NONE) begin
                        owner     <= grant;
                        cmd_type  <= grant;
                        cmd_addr  <= grant_addr;
                        cmd_valid <= 1'b1;
                        arb_busy  <= 1'b1;
                        state     <= A_ISSUE;
                    end
                end

                A_ISSUE: begin
                    // Command is held stable until the engine takes it;
                    // cmd_done is meaningless here and ignored.
                    if (cmd_valid && cmd_ready) begin
                        cmd_valid <= 1'b0;
                        wd_cnt    <= '0;
                        state     <= A_BUSY;
                        case (owner)
                            CMD_REF: ref_ack <= 1'b1;
                            CMD_WR:  wr_ack  <= 1'b1;
                            CMD_RD:  rd_ack  <= 1'b1;
                            default: ;
                        endcase
                    end
                end

                A_BUSY: begin
                    wd_cnt <= wd_cnt + WD_W'(1);
                    // Completion takes precedence over an expiring watchdog.
                    if (cmd_done) begin
                        case (owner)
                            CMD_WR: begin
                                wr_done <= 1'b1;
                                last_rw <= RW_WR;
                            end
                            CMD_RD: begin
                                rd_done <= 1'b1;
                                last_rw <= RW_RD;
                            end
                            default: ;
                        endcase
                        cmd_type <= CMD_NONE;
                        cmd_addr <= '0;
                        arb_busy <= 1'b0;
                        state    <= A_IDLE;
                    end else if (wd_cnt == WD_LIMIT) begin
                        // Engine never finished: flag it for good and free
                        // the arbiter without a done pulse.
                        arb_err  <= 1'b1;
                        cmd_type <= CMD_NONE;
                        cmd_addr <= '0;
                        arb_busy <= 1'b0;
                        state    <= A_IDLE;
                    end
                end

                default: state <= A_INIT;
            endcase
        end
    end

endmodule : sdram_req_arb

// File: tb/tb_sdram_req_arb.sv
// Self-checking bench for sdram_req_arb: directed vector table for the grant
// rules, hand sequences for the multi-cycle corners, then random traffic
// against a transaction-level model of the arbiter.
module tb_sdram_req_arb;

    localparam int AW = 22;
    localparam int TO = 30;

    localparam logic [1:0] T_NONE = 2'd0;
    localparam logic [1:0] T_REF  = 2'd1;
    localparam logic [1:0] T_WR   = 2'd2;
    localparam logic [1:0] T_RD   = 2'd3;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          init_done = 1'b0;
    logic          ref_domain = 1'b0;
    logic          ref_req = 1'b0;
    logic          ref_ack;
    logic          wr_req = 1'b0;
    logic [AW-1:0] wr_addr = '0;
    logic          wr_ack;
    logic          wr_done;
    logic          rd_req = 1'b0;
    logic [AW-1:0] rd_addr = '0;
    logic          rd_ack;
    logic          rd_done;
    logic          cmd_valid;
    logic [1:0]    cmd_type;
    logic [AW-1:0] cmd_addr;
    logic          cmd_ready = 1'b0;
    logic          cmd_done = 1'b0;
    logic          arb_busy;
    logic          arb_err;

    int n_checks = 0;
    int n_fail   = 0;

    sdram_req_arb #(.ADDR_W(AW), .TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n), .init_done(init_done), .ref_domain(ref_domain),
        .ref_req(ref_req), .ref_ack(ref_ack),
        .wr_req(wr_req), .wr_addr(wr_addr), .wr_ack(wr_ack), .wr_done(wr_done),
        .rd_req(rd_req), .rd_addr(rd_addr), .rd_ack(rd_ack), .rd_done(rd_done),
        .cmd_valid(cmd_valid), .cmd_type(cmd_type), .cmd_addr(cmd_addr),
        .cmd_ready(cmd_ready), .cmd_done(cmd_done),
        .arb_busy(arb_busy), .arb_err(arb_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       r;
        logic       dom;
        logic       w;
        logic       rd;
        logic       exp_valid;
        logic [1:0] exp_type;
    } vec_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Outputs are sampled on the falling edge, inputs driven right after.
    task automatic tick();
        @(negedge clk);
    endtask

    function automatic logic [2:0] ack_of(input logic [1:0] t);
        return (t == T_REF) ? 3'b100 : (t == T_WR) ? 3'b010 : (t == T_RD) ? 3'b001 : 3'b000;
    endfunction

    function automatic logic [1:0] done_of(input logic [1:0] t);
        return (t == T_WR) ? 2'b10 : (t == T_RD) ? 2'b01 : 2'b00;
    endfunction

    // Who should win, from the arbitration rules; last_wr=1 means WR served last.
    function automatic logic [1:0] pick(input logic r, input logic d, input logic w,
                                        input logic rr, input logic last_wr);
        if (r) return T_REF;
        if (d) return T_NONE;
        if (w && rr) return last_wr ? T_RD : T_WR;
        if (w) return T_WR;
        if (rr) return T_RD;
        return T_NONE;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        init_done = 0; ref_domain = 0; ref_req = 0; wr_req = 0; rd_req = 0;
        cmd_ready = 0; cmd_done = 0;
        #2 rst_n = 1'b0;
        #1 check("rst_outs", {ref_ack, wr_ack, wr_done, rd_ack, rd_done, cmd_valid,
                              cmd_type, cmd_addr, arb_busy, arb_err}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic go_idle();
        init_done = 1'b1;
        tick();
    endtask

    // Accept the pending command, check the ack, finish it, check the done.
    task automatic complete_cmd(input logic [1:0] t, input string tag);
        cmd_ready = 1'b1;
        tick();
        check({tag, "_ack"}, {ref_ack, wr_ack, rd_ack}, ack_of(t));
        check({tag, "_valid_drop"}, cmd_valid, 1'b0);
        cmd_ready = 1'b0;
        cmd_done = 1'b1;
        tick();
        check({tag, "_done"}, {ref_ack, wr_ack, rd_ack, wr_done, rd_done}, {3'b000, done_of(t)});
        check({tag, "_idle"}, {arb_busy, cmd_type}, 3'b000);
        cmd_done = 1'b0;
        tick();
        check({tag, "_pulses_end"}, {ref_ack, wr_ack, rd_ack, wr_done, rd_done}, 5'b0);
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        logic [AW-1:0] ea;
        string nm;
        nm = $sformatf("vec%0d", idx);
        wr_addr = AW'($urandom);
        rd_addr = AW'($urandom);
        ea = (v.exp_type == T_WR) ? wr_addr : (v.exp_type == T_RD) ? rd_addr : '0;
        ref_req = v.r; ref_domain = v.dom; wr_req = v.w; rd_req = v.rd;
        tick();
        check({nm, "_valid"}, cmd_valid, v.exp_valid);
        if (v.exp_valid) begin
            check({nm, "_type"}, cmd_type, v.exp_type);
            check({nm, "_addr"}, cmd_addr, ea);
        end
        ref_req = 0; ref_domain = 0; wr_req = 0; rd_req = 0;
        if (cmd_valid) complete_cmd(v.exp_type, nm);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation still running at %0t", $time);
        $fatal(1, "timeout");
    end

    initial begin
        vec_t vecs[12];
        int   cnt;
        logic [AW-1:0] a;

        // ref, dom, wr, rd -> valid, type   (history starts as "read last")
        vecs[0]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, T_WR};
        vecs[1]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, T_RD};
        vecs[2]  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, T_REF};
        vecs[3]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, T_WR};
        vecs[4]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, T_NONE};
        vecs[5]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, T_REF};
        vecs[6]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, T_WR};
        vecs[7]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, T_RD};
        vecs[8]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, T_RD};
        vecs[9]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, T_WR};
        vecs[10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, T_NONE};
        vecs[11] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, T_NONE};

        // Init gating: nothing is granted before init_done.
        do_reset();
        a = 22'h2A5A5A;
        wr_req = 1'b1; wr_addr = a;
        cnt = 0;
        for (int i = 0; i < 50; i++) begin
            tick();
            if (cmd_valid) cnt++;
        end
        check("init_hold_valid_cycles", cnt, 0);
        init_done = 1'b1;
        cnt = 0;
        for (int i = 0; i < 4 && !cmd_valid; i++) begin
            tick();
            cnt++;
        end
        check("init_grant_valid", cmd_valid, 1'b1);
        check("init_grant_latency", cnt, 2);
        check("init_grant_type", cmd_type, T_WR);
        check("init_grant_addr", cmd_addr, a);
        wr_req = 1'b0;
        complete_cmd(T_WR, "init");

        // Grant rule table.
        do_reset();
        go_idle();
        for (int i = 0; i < 12; i++) run_vec(vecs[i], i);

        // Continuous WR+RD requests alternate, 10-cycle engine.
        do_reset();
        go_idle();
        wr_req = 1'b1; rd_req = 1'b1;
        wr_addr = 22'h111111; rd_addr = 22'h222222;
        for (int k = 0; k < 4; k++) begin
            for (int i = 0; i < 4 && !cmd_valid; i++) tick();
            check($sformatf("alt%0d_valid", k), cmd_valid, 1'b1);
            check($sformatf("alt%0d_type", k), cmd_type, (k % 2 == 0) ? T_WR : T_RD);
            check($sformatf("alt%0d_addr", k), cmd_addr, (k % 2 == 0) ? 22'h111111 : 22'h222222);
            cmd_ready = 1'b1;
            tick();
            check($sformatf("alt%0d_ack", k), {wr_ack, rd_ack}, (k % 2 == 0) ? 2'b10 : 2'b01);
            cmd_ready = 1'b0;
            tick();
            check($sformatf("alt%0d_ack_width", k), {wr_ack, rd_ack}, 2'b00);
            for (int i = 0; i < 8; i++) tick();
            cmd_done = 1'b1;
            tick();
            check($sformatf("alt%0d_done", k), {wr_done, rd_done}, (k % 2 == 0) ? 2'b10 : 2'b01);
            cmd_done = 1'b0;
            tick();
            check($sformatf("alt%0d_done_width", k), {wr_done, rd_done}, 2'b00);
        end
        wr_req = 1'b0; rd_req = 1'b0;
        if (cmd_valid) complete_cmd(T_WR, "alt_tail");

        // Refresh arriving during a write jumps ahead of a pending read.
        do_reset();
        go_idle();
        wr_req = 1'b1; wr_addr = 22'h0ABCDE;
        tick();
        check("rp_wr_type", cmd_type, T_WR);
        wr_req = 1'b0; cmd_ready = 1'b1;
        tick();
        check("rp_wr_ack", wr_ack, 1'b1);
        cmd_ready = 1'b0;
        ref_req = 1'b1; rd_req = 1'b1; rd_addr = 22'h1F00F0;
        tick(); tick();
        cmd_done = 1'b1;
        tick();
        check("rp_wr_done", {wr_done, cmd_valid}, 2'b10);
        cmd_done = 1'b0;
        tick();
        check("rp_ref_grant", {cmd_valid, cmd_type, cmd_addr}, {1'b1, T_REF, 22'h0});
        cmd_ready = 1'b1;
        tick();
        check("rp_ref_ack", {ref_ack, rd_ack}, 2'b10);
        ref_req = 1'b0; cmd_ready = 1'b0; cmd_done = 1'b1;
        tick();
        check("rp_ref_end", {ref_ack, wr_done, rd_done}, 3'b000);
        cmd_done = 1'b0;
        tick();
        check("rp_rd_grant", {cmd_valid, cmd_type, cmd_addr}, {1'b1, T_RD, 22'h1F00F0});
        rd_req = 1'b0;
        complete_cmd(T_RD, "rp_rd");

        // Refresh window holds off reads but not refresh.
        ref_domain = 1'b1; rd_req = 1'b1; rd_addr = 22'h3C3C3C;
        cnt = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (cmd_valid) cnt++;
        end
        check("dom_block_cycles", cnt, 0);
        ref_req = 1'b1;
        tick();
        check("dom_ref_grant", {cmd_valid, cmd_type}, {1'b1, T_REF});
        ref_req = 1'b0;
        complete_cmd(T_REF, "dom_ref");
        tick();
        check("dom_still_blocked", cmd_valid, 1'b0);
        ref_domain = 1'b0;
        tick();
        check("dom_release_grant", {cmd_valid, cmd_type, cmd_addr}, {1'b1, T_RD, 22'h3C3C3C});
        rd_req = 1'b0;
        complete_cmd(T_RD, "dom_rd");

        // Done arriving in the very cycle the watchdog expires wins.
        wr_req = 1'b1; wr_addr = 22'h000777;
        tick();
        check("tie_grant", {cmd_valid, cmd_type}, {1'b1, T_WR});
        wr_req = 1'b0; cmd_ready = 1'b1;
        tick();
        check("tie_ack", wr_ack, 1'b1);
        cmd_ready = 1'b0;
        for (int i = 1; i <= TO; i++) tick();
        check("tie_pre_err", {arb_err, arb_busy}, 2'b01);
        cmd_done = 1'b1;
        tick();
        check("tie_done", {wr_done, arb_err, arb_busy}, 3'b100);
        cmd_done = 1'b0;

        // Stalled engine: command held; then engine hangs -> sticky error.
        rd_req = 1'b1; rd_addr = 22'h155555;
        tick();
        check("stall_grant", {cmd_valid, cmd_type, cmd_addr}, {1'b1, T_RD, 22'h155555});
        rd_req = 1'b0;
        for (int i = 0; i < 20; i++) begin
            cmd_done = (i == 5);
            tick();
            check($sformatf("stall_hold%0d", i), {cmd_valid, cmd_type, cmd_addr, rd_ack, rd_done},
                  {1'b1, T_RD, 22'h155555, 2'b00});
        end
        cmd_done = 1'b0; cmd_ready = 1'b1;
        tick();
        check("stall_ack", {rd_ack, cmd_valid}, 2'b10);
        cmd_ready = 1'b0;
        for (int i = 1; i <= TO; i++) tick();
        check("wd_before_limit", {arb_err, arb_busy}, 2'b01);
        tick();
        check("wd_fire", {arb_err, arb_busy, rd_done, cmd_type}, {1'b1, 1'b0, 1'b0, T_NONE});
        wr_req = 1'b1; wr_addr = 22'h0F0F0F;
        tick();
        check("wd_after_grant", {cmd_valid, cmd_type}, {1'b1, T_WR});
        wr_req = 1'b0;
        complete_cmd(T_WR, "wd_after");
        check("wd_sticky", arb_err, 1'b1);

        // Reset in the middle of a command.
        wr_req = 1'b1; wr_addr = 22'h2BCDEF;
        tick();
        wr_req = 1'b0; cmd_ready = 1'b1;
        tick();
        cmd_ready = 1'b0;
        tick();
        check("mid_busy_pre", {arb_busy, cmd_type}, {1'b1, T_WR});
        #2 rst_n = 1'b0;
        #1 check("mid_rst_outs", {ref_ack, wr_ack, wr_done, rd_ack, rd_done, cmd_valid,
                                  cmd_type, cmd_addr, arb_busy, arb_err}, 64'd0);
        init_done = 1'b0; wr_req = 1'b1;
        tick();
        rst_n = 1'b1;
        cnt = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (cmd_valid || wr_done || wr_ack) cnt++;
        end
        check("mid_rst_wait_init", cnt, 0);
        init_done = 1'b1;
        for (int i = 0; i < 4 && !cmd_valid; i++) tick();
        check("mid_rst_regrant", {cmd_valid, cmd_type, cmd_addr}, {1'b1, T_WR, 22'h2BCDEF});
        wr_req = 1'b0;
        complete_cmd(T_WR, "mid_rst");

        // Random traffic against a transaction-level model.
        do_reset();
        go_idle();
        begin
            int            m;          // 0 free, 1 command offered, 2 engine working
            logic [1:0]    m_owner;
            logic [AW-1:0] m_addr;
            logic          m_last_wr;
            int            busy_left;
            logic          p_r, p_d, p_w, p_rr, p_rdy, p_done;
            logic [AW-1:0] p_wa, p_ra, act_addr;
            logic [2:0]    e_ack;
            logic [1:0]    e_done, g;
            m = 0; m_owner = T_NONE; m_addr = '0; m_last_wr = 1'b0; busy_left = 0;
            for (int cyc = 0; cyc < 4000; cyc++) begin
                p_r = ref_req; p_d = ref_domain; p_w = wr_req; p_rr = rd_req;
                p_wa = wr_addr; p_ra = rd_addr; p_rdy = cmd_ready; p_done = cmd_done;
                tick();
                e_ack = 3'b0; e_done = 2'b0;
                if (m == 0) begin
                    g = pick(p_r, p_d, p_w, p_rr, m_last_wr);
                    if (g != T_NONE) begin
                        m = 1; m_owner = g;
                        m_addr = (g == T_WR) ? p_wa : (g == T_RD) ? p_ra : '0;
                    end
                end else if (m == 1) begin
                    if (p_rdy) begin
                        m = 2; e_ack = ack_of(m_owner);
                        busy_left = $urandom_range(0, 6);
                    end
                end else if (p_done) begin
                    e_done = done_of(m_owner);
                    if (m_owner == T_WR) m_last_wr = 1'b1;
                    else if (m_owner == T_RD) m_last_wr = 1'b0;
                    m = 0;
                end
                act_addr = cmd_valid ? cmd_addr : '0;
                check($sformatf("rand_cyc%0d", cyc),
                      {cmd_valid, cmd_type, act_addr, ref_ack, wr_ack, rd_ack, wr_done, rd_done, arb_busy, arb_err},
                      {(m == 1), (m != 0) ? m_owner : T_NONE, (m == 1) ? m_addr : '0,
                       e_ack, e_done, (m != 0), 1'b0});
                // Client behaviour for the next cycle.
                if (ref_ack) ref_req = 1'b0;
                else if (!ref_req && $urandom_range(0, 19) == 0) ref_req = 1'b1;
                if (wr_ack || (wr_req && $urandom_range(0, 49) == 0)) wr_req = 1'b0;
                else if (!wr_req && $urandom_range(0, 3) == 0) begin
                    wr_req = 1'b1; wr_addr = AW'($urandom);
                end
                if (rd_ack || (rd_req && $urandom_range(0, 49) == 0)) rd_req = 1'b0;
                else if (!rd_req && $urandom_range(0, 3) == 0) begin
                    rd_req = 1'b1; rd_addr = AW'($urandom);
                end
                if ($urandom_range(0, 15) == 0) ref_domain = ~ref_domain;
                cmd_ready = 1'($urandom_range(0, 1));
                if (m == 2) begin
                    if (busy_left == 0) cmd_done = 1'b1;
                    else begin
                        busy_left--;
                        cmd_done = 1'b0;
                    end
                end else if (m == 1) begin
                    cmd_done = ($urandom_range(0, 7) == 0);
                end else begin
                    cmd_done = 1'b0;
                end
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_sdram_req_arb
